// File: rtl/crosswalk_controller.sv
`default_nettype none
// ============================================================================
// Module      : crosswalk_controller
// Description : Moore FSM sequencing car lamps and pedestrian walk lamps for
//               one intersection, with per-state timer and request latching.
// Revision    : 1.0 - initial release
// ============================================================================

module crosswalk_controller #(
  parameter int MIN_GREEN = 8,
  parameter int YELLOW_T  = 3,
  parameter int WALK_T    = 6,
  parameter int FLASH_T   = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sx,
  input  logic       sy,
  output logic       car_g,
  output logic       car_y,
  output logic       car_r,
  output logic       walk_x,
  output logic       walk_y,
  output logic       flash,
  output logic       pend_x,
  output logic       pend_y,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_WALK   = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_GREEN_LAST  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] c_YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] c_WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] c_FLASH_LAST  = CNT_W'(FLASH_T - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_timer;
  logic               r_pend_x;
  logic               r_pend_y;
  logic               r_serve_x;
  logic               r_serve_y;
  logic               r_car_g;
  logic               r_car_y;
  logic               r_car_r;
  logic               r_walk_x;
  logic               r_walk_y;
  logic               r_flash;

  state_t             w_nxt_state;
  logic [CNT_W-1:0]   w_nxt_timer;
  logic               w_nxt_pend_x;
  logic               w_nxt_pend_y;
  logic               w_nxt_serve_x;
  logic               w_nxt_serve_y;
  logic               w_green_done;

  assign w_green_done = (r_timer >= c_GREEN_LAST);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_timer   = r_timer + CNT_W'(1);
    w_nxt_pend_x  = r_pend_x | sx;
    w_nxt_pend_y  = r_pend_y | sy;
    w_nxt_serve_x = r_serve_x;
    w_nxt_serve_y = r_serve_y;

    case (r_state)
      S_GREEN: begin
        if (w_green_done && (r_pend_x || r_pend_y || sx || sy)) begin
          w_nxt_state = S_YELLOW;
        end else if (w_green_done) begin
          // Hold at the last GREEN count so an idle road never wraps the timer.
          w_nxt_timer = r_timer;
        end
      end
      S_YELLOW: begin
        if (r_timer == c_YELLOW_LAST) begin
          w_nxt_state   = S_WALK;
          // A request present on the entry edge is served now, not re-latched.
          w_nxt_serve_x = r_pend_x | sx;
          w_nxt_serve_y = r_pend_y | sy;
          w_nxt_pend_x  = 1'b0;
          w_nxt_pend_y  = 1'b0;
        end
      end
      S_WALK: begin
        if (r_timer == c_WALK_LAST) begin
          w_nxt_state = S_FLASH;
        end
      end
      S_FLASH: begin
        if (r_timer == c_FLASH_LAST) begin
          w_nxt_state   = S_GREEN;
          w_nxt_serve_x = 1'b0;
          w_nxt_serve_y = 1'b0;
        end
      end
      default: begin
        w_nxt_state = S_GREEN;
      end
    endcase

    if (w_nxt_state != r_state) begin
      w_nxt_timer = '0;
    end
  end

  // Lamp registers are loaded from the next-state values so they line up with
  // the state register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_GREEN;
      r_timer   <= '0;
      r_pend_x  <= 1'b0;
      r_pend_y  <= 1'b0;
      r_serve_x <= 1'b0;
      r_serve_y <= 1'b0;
      r_car_g   <= 1'b1;
      r_car_y   <= 1'b0;
      r_car_r   <= 1'b0;
      r_walk_x  <= 1'b0;
      r_walk_y  <= 1'b0;
      r_flash   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_timer   <= w_nxt_timer;
      r_pend_x  <= w_nxt_pend_x;
      r_pend_y  <= w_nxt_pend_y;
      r_serve_x <= w_nxt_serve_x;
      r_serve_y <= w_nxt_serve_y;
      r_car_g   <= (w_nxt_state == S_GREEN);
      r_car_y   <= (w_nxt_state == S_YELLOW);
      r_car_r   <= (w_nxt_state == S_WALK) || (w_nxt_state == S_FLASH);
      r_walk_x  <= (w_nxt_state == S_WALK) && w_nxt_serve_x;
      r_walk_y  <= (w_nxt_state == S_WALK) && w_nxt_serve_y;
      r_flash   <= (w_nxt_state == S_FLASH) && !w_nxt_timer[0];
    end
  end

  assign car_g  = r_car_g;
  assign car_y  = r_car_y;
  assign car_r  = r_car_r;
  assign walk_x = r_walk_x;
  assign walk_y = r_walk_y;
  assign flash  = r_flash;
  assign pend_x = r_pend_x;
  assign pend_y = r_pend_y;
  assign state  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_crosswalk_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_crosswalk_controller
// Description : Self-checking bench for crosswalk_controller.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_crosswalk_controller;

  localparam int MIN_GREEN = 8;
  localparam int YELLOW_T  = 3;
  localparam int WALK_T    = 6;
  localparam int FLASH_T   = 4;
  localparam int CNT_W     = 8;
  localparam logic [9:0] c_IDLE = 10'b1000000000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sx    = 1'b0;
  logic       sy    = 1'b0;
  logic       car_g, car_y, car_r, walk_x, walk_y, flash, pend_x, pend_y;
  logic [1:0] state;
  int         checks = 0;
  int         errors = 0;

  crosswalk_controller #(
    .MIN_GREEN(MIN_GREEN), .YELLOW_T(YELLOW_T), .WALK_T(WALK_T),
    .FLASH_T(FLASH_T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy),
    .car_g(car_g), .car_y(car_y), .car_r(car_r),
    .walk_x(walk_x), .walk_y(walk_y), .flash(flash),
    .pend_x(pend_x), .pend_y(pend_y), .state(state)
  );

  always #5 clk = ~clk;

  wire [9:0] obs = {car_g, car_y, car_r, walk_x, walk_y, flash, pend_x, pend_y, state};

  // Reference model: phase index, cycles already spent in it, request sets.
  int dur [4] = '{MIN_GREEN, YELLOW_T, WALK_T, FLASH_T};
  int m_ph, m_age;
  bit m_px, m_py, m_wx, m_wy;

  function automatic void model_reset();
    m_ph = 0; m_age = 0;
    m_px = 0; m_py = 0; m_wx = 0; m_wy = 0;
  endfunction

  function automatic void model_edge(bit x, bit y);
    bit leave;
    int done_cycles;
    done_cycles = m_age + 1;
    if (m_ph == 0) leave = (done_cycles >= dur[0]) && (m_px || m_py || x || y);
    else           leave = (done_cycles == dur[m_ph]);
    if (leave && m_ph == 1) begin
      m_wx = m_px | x; m_wy = m_py | y; m_px = 0; m_py = 0;
    end else begin
      m_px = m_px | x; m_py = m_py | y;
    end
    if (leave && m_ph == 3) begin m_wx = 0; m_wy = 0; end
    if (leave) begin m_ph = (m_ph + 1) % 4; m_age = 0; end
    else m_age = m_age + 1;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_ph == 0, m_ph == 1, m_ph >= 2, (m_ph == 2) && m_wx, (m_ph == 2) && m_wy,
            (m_ph == 3) && (m_age % 2 == 0), m_px, m_py, 2'(m_ph)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(sx, sy);
    #1;
  endtask

  task automatic do_reset();
    sx = 0; sy = 0;
    rst_n = 0; model_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  // Cycle-level invariants: one-hot car lamps, walk only under red, phase length.
  int         run_len = 0;
  logic [1:0] prev_st = 2'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      run_len = (state == prev_st && run_len != 0) ? run_len + 1 : 1;
      checks++;
      if ($countones({car_g, car_y, car_r}) != 1 || ((walk_x || walk_y) && !car_r) ||
          (state != 2'd0 && run_len > dur[state])) begin
        errors++;
        $display("FAIL invariant t=%0t lamps(gyr)=%b%b%b walk=%b%b state=%0d run=%0d; need one-hot lamps, walk only with red, run<=%0d",
                 $time, car_g, car_y, car_r, walk_x, walk_y, state, run_len, dur[state]);
      end
    end
    prev_st = state;
  end

  task automatic test_reset();
    rst_n = 0; model_reset();
    repeat (3) tick();
    checks++;
    if (obs !== c_IDLE) begin
      errors++; $display("FAIL reset_state got=%b want=%b", obs, c_IDLE);
    end
    rst_n = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (obs !== c_IDLE) begin
        errors++; $display("FAIL reset_idle cycle=%0d got=%b want=%b", i, obs, c_IDLE);
      end
    end
  endtask

  task automatic test_single_request();
    int g = 0, y = 0, w = 0, b = 0;
    logic [3:0] fl;
    do_reset();
    while (car_g && g < 40) begin
      g++;
      sx = (g == 3);
      if (g == 4) begin
        checks++;
        if (pend_x !== 1'b1) begin
          errors++; $display("FAIL pend_after_pulse got=%b want=1", pend_x);
        end
      end
      tick();
    end
    sx = 0;
    checks++;
    if (g != MIN_GREEN) begin errors++; $display("FAIL green_len got=%0d want=%0d", g, MIN_GREEN); end
    while (car_y && y < 20) begin y++; tick(); end
    checks++;
    if (y != YELLOW_T) begin errors++; $display("FAIL yellow_len got=%0d want=%0d", y, YELLOW_T); end
    while (car_r && walk_x && !walk_y && w < 20) begin w++; tick(); end
    checks++;
    if (w != WALK_T) begin errors++; $display("FAIL walk_x_len got=%0d want=%0d", w, WALK_T); end
    for (int i = 0; i < 4; i++) begin
      fl[3-i] = flash & car_r & (state == 2'd3);
      tick();
    end
    checks++;
    if (fl !== 4'b1010) begin errors++; $display("FAIL flash_pattern got=%b want=1010", fl); end
    checks++;
    if (car_g !== 1'b1 || pend_x !== 1'b0) begin
      errors++; $display("FAIL back_to_green car_g=%b pend_x=%b want 1,0", car_g, pend_x);
    end
    b = 0;
  endtask

  task automatic test_both_requests();
    int b = 0, w = 0;
    do_reset();
    sx = 1; sy = 1;
    tick();
    sx = 0; sy = 0;
    while (!car_r && b < 40) begin b++; tick(); end
    while (walk_x && walk_y && w < 20) begin w++; tick(); end
    checks++;
    if (w != WALK_T) begin errors++; $display("FAIL both_walk_len got=%0d want=%0d", w, WALK_T); end
  endtask

  task automatic test_late_request();
    int b = 0, g = 0;
    bit saw_y = 0;
    do_reset();
    sx = 1; tick(); sx = 0;
    while (!walk_x && b < 40) begin b++; tick(); end
    tick(); tick();
    sy = 1; tick(); sy = 0;
    checks++;
    if (pend_y !== 1'b1 || walk_y !== 1'b0) begin
      errors++; $display("FAIL late_pend pend_y=%b walk_y=%b want 1,0", pend_y, walk_y);
    end
    b = 0;
    while (!car_g && b < 40) begin saw_y |= walk_y; b++; tick(); end
    checks++;
    if (saw_y) begin errors++; $display("FAIL late_served_early walk_y=1 want 0 this phase"); end
    while (car_g && g < 40) begin g++; tick(); end
    checks++;
    if (g != MIN_GREEN) begin errors++; $display("FAIL late_green_len got=%0d want=%0d", g, MIN_GREEN); end
    b = 0;
    while (state != 2'd2 && b < 40) begin b++; tick(); end
    checks++;
    if (walk_y !== 1'b1 || walk_x !== 1'b0) begin
      errors++; $display("FAIL late_second_phase walk_x=%b walk_y=%b want 0,1", walk_x, walk_y);
    end
  endtask

  task automatic test_reset_mid_walk();
    int b = 0;
    do_reset();
    sx = 1; tick(); sx = 0;
    while (state != 2'd2 && b < 40) begin b++; tick(); end
    sy = 1; tick(); sy = 0;
    rst_n = 0; model_reset();
    #1;
    checks++;
    if (car_g !== 1'b1 || walk_x !== 1'b0 || car_r !== 1'b0 || pend_x !== 1'b0 || pend_y !== 1'b0) begin
      errors++;
      $display("FAIL async_reset car_g=%b walk_x=%b car_r=%b pend=%b%b want 1,0,0,00",
               car_g, walk_x, car_r, pend_x, pend_y);
    end
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (obs !== c_IDLE) begin
        errors++; $display("FAIL post_reset_idle cycle=%0d got=%b want=%b", i, obs, c_IDLE);
      end
    end
  endtask

  task automatic test_random();
    int dens;
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      dens = $urandom_range(1, 14);
      for (int i = 0; i < 100; i++) begin
        if (blk == 5 && i == 37) begin
          rst_n = 0; model_reset();
          #1;
          checks++;
          if (obs !== exp_vec()) begin
            errors++; $display("FAIL rand_async_reset got=%b want=%b", obs, exp_vec());
          end
          sx = 0; sy = 0;
          tick();
          rst_n = 1;
        end
        if (blk == 3) begin
          sx = 1; sy = (i >= 50);
        end else begin
          sx = ($urandom_range(0, dens) == 0);
          sy = ($urandom_range(0, dens) == 0);
        end
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL rand_model blk=%0d cyc=%0d got(gyr wxy f pxy st)=%b want=%b",
                   blk, i, obs, exp_vec());
        end
      end
    end
    sx = 0; sy = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_request();
    test_both_requests();
    test_late_request();
    test_reset_mid_walk();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
